// File: rtl/scr1_axi_rd_arb_if.sv
// AXI4 read address + read data bundle, N request lanes sharing one R return.
interface scr1_axi_rd_arb_if #(
   parameter int N   = 2,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 3
);
   logic [N-1:0]     arvalid;
   logic [N-1:0]     arready;
   logic [N*AW-1:0]  araddr;
   logic [N*IDW-1:0] arid;
   logic [N*8-1:0]   arlen;
   logic [N*3-1:0]   arsize;
   logic [N*2-1:0]   arburst;
   logic [N-1:0]     rvalid;
   logic [N-1:0]     rready;
   logic [IDW-1:0]   rid;
   logic [DW-1:0]    rdata;
   logic [1:0]       rresp;
   logic             rlast;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rid, rdata, rresp, rlast
   );
endinterface

// File: rtl/scr1_axi_rd_arb.sv
// 2:1 AXI4 read arbiter (IMEM=M0, DMEM=M1), one transaction in flight.
// SCR1_AXI_RD_ARB_FIXED_PRIO_EN: M1 always wins ties instead of round-robin.
module scr1_axi_rd_arb #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   scr1_axi_rd_arb_if.slave  m_if,
   scr1_axi_rd_arb_if.master s_if,
   output logic              busy_o,
   output logic              grant_o
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_e;

   state_e         state_q, state_d;
   logic           grant_q, grant_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [7:0]     len_q, len_d;
   logic [2:0]     size_q, size_d;
   logic [1:0]     burst_q, burst_d;
   logic [IDW:0]   id_q, id_d;
   logic           any_req;
   logic           win;

   assign any_req = |m_if.arvalid;

`ifdef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
   assign win = m_if.arvalid[1];
`else
   logic last_q, last_d;

   // On a tie the master that did not own the previous transaction wins
   assign win = (&m_if.arvalid) ? ~last_q : m_if.arvalid[1];
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      size_d       = size_q;
      burst_d      = burst_q;
      id_d         = id_q;
`ifndef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
      last_d       = last_q;
`endif
      m_if.arready = '0;
      m_if.rvalid  = '0;
      s_if.arvalid = 1'b0;
      s_if.rready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               m_if.arready = win ? 2'b10 : 2'b01;
               addr_d  = win ? m_if.araddr[2*AW-1:AW]
                             : m_if.araddr[AW-1:0];
               len_d   = win ? m_if.arlen[15:8]
                             : m_if.arlen[7:0];
               size_d  = win ? m_if.arsize[5:3]
                             : m_if.arsize[2:0];
               burst_d = win ? m_if.arburst[3:2]
                             : m_if.arburst[1:0];
               id_d    = {win, win ? m_if.arid[2*IDW-1:IDW]
                                   : m_if.arid[IDW-1:0]};
               grant_d = win;
               state_d = ADDR;
            end
         end
         ADDR: begin
            s_if.arvalid = 1'b1;
            if (s_if.arready[0]) begin
               state_d = DATA;
            end
         end
         DATA: begin
            m_if.rvalid[grant_q] = s_if.rvalid[0];
            s_if.rready = m_if.rready[grant_q];
            if (s_if.rvalid[0] && s_if.rready[0] && s_if.rlast) begin
`ifndef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
               last_d  = grant_q;
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         id_q    <= '0;
`ifndef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         id_q    <= id_d;
`ifndef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   assign s_if.araddr  = addr_q;
   assign s_if.arlen   = len_q;
   assign s_if.arsize  = size_q;
   assign s_if.arburst = burst_q;
   assign s_if.arid    = id_q;

   // R payload is broadcast; only rvalid is steered to the owner
   assign m_if.rid   = s_if.rid[IDW-1:0];
   assign m_if.rdata = s_if.rdata;
   assign m_if.rresp = s_if.rresp;
   assign m_if.rlast = s_if.rlast;

   assign busy_o  = (state_q != IDLE);
   assign grant_o = grant_q;

`ifndef SYNTHESIS
   rid_owner_a : assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == DATA && s_if.rvalid[0]) |-> (s_if.rid[IDW] == grant_q)
   );
`endif

endmodule

// File: tb/tb_scr1_axi_rd_arb.sv
// Scoreboard bench for scr1_axi_rd_arb: directed requests, queued expectations.
module tb_scr1_axi_rd_arb;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  id;
      logic [1:0]  resp;
      logic        last;
   } r_t;

   logic clk;
   logic rst_n;
   logic busy;
   logic grant;

   int total = 0;
   int bad   = 0;

   ar_t exp_ar[$];
   r_t  exp_r0[$];
   r_t  exp_r1[$];
   ar_t cmdq[$];

   scr1_axi_rd_arb_if #(.N(2), .AW(32), .DW(32), .IDW(3)) m_if ();
   scr1_axi_rd_arb_if #(.N(1), .AW(32), .DW(32), .IDW(4)) s_if ();

   scr1_axi_rd_arb #(.AW(32), .DW(32), .IDW(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_if    (m_if),
      .s_if    (s_if),
      .busy_o  (busy),
      .grant_o (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic exp_push(input int m, input logic [31:0] a,
                           input logic [2:0] id, input logic [7:0] len);
      ar_t e;
      r_t  r;
      e.addr  = a;
      e.id    = {m[0], id};
      e.len   = len;
      e.size  = m[0] ? 3'd1 : 3'd2;
      e.burst = m[0] ? 2'b10 : 2'b01;
      exp_ar.push_back(e);
      for (int k = 0; k <= int'(len); k++) begin
         r.data = a + k;
         r.id   = id;
         r.resp = k[1:0];
         r.last = (k == int'(len));
         if (m[0]) exp_r1.push_back(r);
         else      exp_r0.push_back(r);
      end
   endtask

   task automatic set_m(input int m, input logic [31:0] a,
                        input logic [2:0] id, input logic [7:0] len);
      m_if.araddr[m*32 +: 32] = a;
      m_if.arid[m*3 +: 3]     = id;
      m_if.arlen[m*8 +: 8]    = len;
      m_if.arsize[m*3 +: 3]   = m[0] ? 3'd1 : 3'd2;
      m_if.arburst[m*2 +: 2]  = m[0] ? 2'b10 : 2'b01;
   endtask

   // Raise the masked requests and hold each until its own handshake
   task automatic issue(input logic [1:0] mask,
                        input logic [31:0] a0, input logic [2:0] i0,
                        input logic [7:0] l0,
                        input logic [31:0] a1, input logic [2:0] i1,
                        input logic [7:0] l1);
      logic [1:0] pend;
      logic [1:0] done;
      pend = mask;
      if (mask[0]) set_m(0, a0, i0, l0);
      if (mask[1]) set_m(1, a1, i1, l1);
      m_if.arvalid = m_if.arvalid | mask;
      for (int c = 0; c < 2000 && pend != 2'b00; c++) begin
         @(negedge clk);
         done = pend & m_if.arvalid & m_if.arready;
         @(posedge clk);
         #1;
         pend         = pend & ~done;
         m_if.arvalid = m_if.arvalid & ~done;
      end
      if (pend != 2'b00) chk("issue_timeout", {62'd0, pend}, 64'd0);
   endtask

   task automatic wait_idle(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!busy && exp_ar.size() == 0 && exp_r0.size() == 0 &&
             exp_r1.size() == 0) break;
      end
      if (c == budget) chk("idle_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Slave model: beat k of a burst carries addr+k, resp=k[1:0], rid=arid
   initial begin
      int   beat;
      logic ar_fire;
      logic r_fire;
      beat        = 0;
      s_if.rvalid = '0;
      s_if.rid    = '0;
      s_if.rdata  = '0;
      s_if.rresp  = '0;
      s_if.rlast  = 1'b0;
      forever begin
         @(negedge clk);
         ar_fire = s_if.arvalid[0] && s_if.arready[0];
         r_fire  = s_if.rvalid[0] && s_if.rready[0];
         if (ar_fire)
            cmdq.push_back('{s_if.araddr, s_if.arid, s_if.arlen,
                             s_if.arsize, s_if.arburst});
         @(posedge clk);
         #1;
         if (!rst_n) begin
            cmdq.delete();
            beat        = 0;
            s_if.rvalid = '0;
            s_if.rlast  = 1'b0;
            continue;
         end
         if (r_fire && cmdq.size() > 0) begin
            if (beat == int'(cmdq[0].len)) begin
               void'(cmdq.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (cmdq.size() > 0) begin
            s_if.rvalid = 1'b1;
            s_if.rid    = cmdq[0].id;
            s_if.rdata  = cmdq[0].addr + beat;
            s_if.rresp  = beat[1:0];
            s_if.rlast  = (beat == int'(cmdq[0].len));
         end else begin
            s_if.rvalid = '0;
            s_if.rlast  = 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever a handshake is presented
   initial begin
      ar_t e;
      r_t  r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (s_if.arvalid[0] && s_if.arready[0]) begin
               if (exp_ar.size() == 0) begin
                  chk("ar_unexpected", 64'd1, 64'd0);
               end else begin
                  e = exp_ar.pop_front();
                  chk("ar_addr", s_if.araddr, e.addr);
                  chk("ar_id", s_if.arid, e.id);
                  chk("ar_len", s_if.arlen, e.len);
                  chk("ar_size", s_if.arsize, e.size);
                  chk("ar_burst", s_if.arburst, e.burst);
               end
            end
            if (&m_if.rvalid) chk("rvalid_both", m_if.rvalid, 2'b00);
            for (int m = 0; m < 2; m++) begin
               if (m_if.rvalid[m] && m_if.rready[m]) begin
                  if ((m == 0 ? exp_r0.size() : exp_r1.size()) == 0) begin
                     chk($sformatf("r%0d_unexpected", m), 64'd1, 64'd0);
                  end else begin
                     r = (m == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                     chk($sformatf("r%0d_data", m), m_if.rdata, r.data);
                     chk($sformatf("r%0d_id", m), m_if.rid, r.id);
                     chk($sformatf("r%0d_resp", m), m_if.rresp, r.resp);
                     chk($sformatf("r%0d_last", m), m_if.rlast, r.last);
                  end
               end
            end
         end
      end
   end

   initial begin
      int c;
      int n;
      rst_n          = 1'b0;
      m_if.arvalid   = '0;
      m_if.araddr    = '0;
      m_if.arid      = '0;
      m_if.arlen     = '0;
      m_if.arsize    = '0;
      m_if.arburst   = '0;
      m_if.rready    = 2'b11;
      s_if.arready   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_arready", m_if.arready, 2'b00);
      chk("rst_m_rvalid", m_if.rvalid, 2'b00);
      chk("rst_s_arvalid", s_if.arvalid, 1'b0);
      chk("rst_s_rready", s_if.rready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two rounds of simultaneous requests
`ifdef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
      exp_push(1, 32'h200, 3'd2, 8'd1);
      exp_push(0, 32'h100, 3'd1, 8'd1);
`else
      exp_push(0, 32'h100, 3'd1, 8'd1);
      exp_push(1, 32'h200, 3'd2, 8'd1);
`endif
      issue(2'b11, 32'h100, 3'd1, 8'd1, 32'h200, 3'd2, 8'd1);
`ifdef SCR1_AXI_RD_ARB_FIXED_PRIO_EN
      exp_push(1, 32'h400, 3'd4, 8'd1);
      exp_push(0, 32'h300, 3'd3, 8'd1);
`else
      exp_push(0, 32'h300, 3'd3, 8'd1);
      exp_push(1, 32'h400, 3'd4, 8'd1);
`endif
      issue(2'b11, 32'h300, 3'd3, 8'd1, 32'h400, 3'd4, 8'd1);
      wait_idle(200);

      // M0 alone: AR latency, beat routing, busy release
      exp_push(0, 32'h1000, 3'd5, 8'd3);
      set_m(0, 32'h1000, 3'd5, 8'd3);
      m_if.arvalid[0] = 1'b1;
      @(negedge clk);
      chk("m0_arready_T", m_if.arready, 2'b01);
      chk("m0_s_arvalid_T", s_if.arvalid, 1'b0);
      @(posedge clk);
      #1 m_if.arvalid[0] = 1'b0;
      @(negedge clk);
      chk("m0_s_arvalid_T1", s_if.arvalid, 1'b1);
      chk("m0_s_arid_T1", s_if.arid, 4'b0101);
      chk("m0_busy_T1", busy, 1'b1);
      chk("m0_grant_T1", grant, 1'b0);
      for (c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_if.rvalid[0] && m_if.rready[0] && m_if.rlast) break;
      end
      if (c == 40) chk("m0_rlast_timeout", 64'd0, 64'd1);
      @(negedge clk);
      chk("m0_busy_after_last", busy, 1'b0);
      chk("m0_beats_left", exp_r0.size(), 64'd0);
      @(posedge clk);
      #1;

      // Slave AR stall for 10 cycles with a competing M0 request
      s_if.arready = 1'b0;
      exp_push(1, 32'h2000, 3'd3, 8'd2);
      set_m(1, 32'h2000, 3'd3, 8'd2);
      m_if.arvalid[1] = 1'b1;
      @(negedge clk);
      chk("stall_arready_T", m_if.arready, 2'b10);
      @(posedge clk);
      #1;
      m_if.arvalid[1] = 1'b0;
      set_m(0, 32'h2100, 3'd4, 8'd0);
      m_if.arvalid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_s_arvalid", s_if.arvalid, 1'b1);
         chk("stall_s_araddr", s_if.araddr, 32'h2000);
         chk("stall_s_arid", s_if.arid, 4'b1011);
         chk("stall_s_arlen", s_if.arlen, 8'd2);
         chk("stall_m_arready", m_if.arready, 2'b00);
      end
      @(posedge clk);
      #1 s_if.arready = 1'b1;
      exp_push(0, 32'h2100, 3'd4, 8'd0);
      issue(2'b01, 32'h2100, 3'd4, 8'd0, 32'h0, 3'd0, 8'd0);
      wait_idle(200);

      // Single-beat burst, M1 back-pressures the rlast beat
      m_if.rready[1] = 1'b0;
      exp_push(1, 32'h5000, 3'd6, 8'd0);
      issue(2'b10, 32'h0, 3'd0, 8'd0, 32'h5000, 3'd6, 8'd0);
      for (c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_if.rvalid[1]) break;
      end
      if (c == 40) chk("hold_rvalid_timeout", 64'd0, 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("hold_s_rready", s_if.rready, 1'b0);
         chk("hold_m_rvalid", m_if.rvalid, 2'b10);
         chk("hold_m_rlast", m_if.rlast, 1'b1);
         chk("hold_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1 m_if.rready[1] = 1'b1;
      @(negedge clk);
      chk("hold_release_s_rready", s_if.rready, 1'b1);
      @(negedge clk);
      chk("hold_busy_done", busy, 1'b0);
      @(posedge clk);
      #1;

      // Reset pulse during beat 2 of 4
      exp_push(0, 32'h3000, 3'd1, 8'd3);
      issue(2'b01, 32'h3000, 3'd1, 8'd3, 32'h0, 3'd0, 8'd0);
      n = 0;
      for (c = 0; c < 50 && n < 2; c++) begin
         @(negedge clk);
         if (m_if.rvalid[0] && m_if.rready[0]) n++;
      end
      if (n < 2) chk("rstmid_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_m_rvalid", m_if.rvalid, 2'b00);
      chk("rstmid_s_rready", s_if.rready, 1'b0);
      chk("rstmid_s_arvalid", s_if.arvalid, 1'b0);
      chk("rstmid_m_arready", m_if.arready, 2'b00);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_grant", grant, 1'b0);
      chk("rstmid_pending", exp_r0.size(), 64'd2);
      exp_r0.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_push(1, 32'h6000, 3'd7, 8'd1);
      issue(2'b10, 32'h0, 3'd0, 8'd0, 32'h6000, 3'd7, 8'd1);
      wait_idle(200);
      chk("post_rst_grant", grant, 1'b1);

      // Maximum burst length ends on rlast only
      exp_push(0, 32'h8000, 3'd2, 8'd255);
      issue(2'b01, 32'h8000, 3'd2, 8'd255, 32'h0, 3'd0, 8'd0);
      wait_idle(600);

      chk("end_ar_left", exp_ar.size(), 64'd0);
      chk("end_r0_left", exp_r0.size(), 64'd0);
      chk("end_r1_left", exp_r1.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
